// File: rtl/softmax_max_sub_bf16_pkg.sv
// Shared types and helpers for the BF16 softmax max-subtract stage.
package softmax_max_sub_bf16_pkg;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  localparam logic [15:0] BF16_SIGN  = 16'h8000;
  localparam logic [15:0] BF16_ONE   = 16'h3F80;
  localparam logic [15:0] BF16_PZERO = 16'h0000;

  // Monotonic unsigned key: -0 < +0, -NaN below -inf, +NaN above +inf.
  function automatic logic [15:0] bf16_key(input logic [15:0] b);
    return b[15] ? ~b : (b | BF16_SIGN);
  endfunction

endpackage

// File: rtl/FP_ADD_BF16.sv
// BF16 adder with round-to-nearest-even and LAT output register stages.
module FP_ADD_BF16 #(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inA,
  input  logic [15:0] inB,
  output logic [15:0] out
);

  logic [15:0] w_res;

  always_comb begin : add_core
    logic [15:0] lv, sv;
    logic [7:0]  el, es, ml, ms, d, dc;
    logic [25:0] tmp;
    logic [10:0] big, ali, n;
    logic [11:0] s;
    logic [8:0]  e;
    logic [3:0]  lz, sh;
    logic [14:0] mag;
    logic        nan_a, nan_b, inf_a, inf_b;
    // Larger magnitude goes first so the mantissa difference never underflows.
    lv  = (inB[14:0] > inA[14:0]) ? inB : inA;
    sv  = (inB[14:0] > inA[14:0]) ? inA : inB;
    el  = (lv[14:7] == 8'd0) ? 8'd1 : lv[14:7];
    es  = (sv[14:7] == 8'd0) ? 8'd1 : sv[14:7];
    ml  = {lv[14:7] != 8'd0, lv[6:0]};
    ms  = {sv[14:7] != 8'd0, sv[6:0]};
    d   = el - es;
    dc  = (d > 8'd18) ? 8'd18 : d;
    tmp = {ms, 18'd0} >> dc;
    ali = {tmp[25:16], |tmp[15:0]};
    big = {ml, 3'b000};
    s   = (lv[15] == sv[15]) ? ({1'b0, big} + {1'b0, ali}) : ({1'b0, big} - {1'b0, ali});
    e   = {1'b0, el};
    lz  = 4'd11;
    for (int i = 0; i <= 10; i++) begin
      if (s[i]) lz = 4'(10 - i);
    end
    sh = (9'(lz) > (e - 9'd1)) ? 4'(e - 9'd1) : lz;
    if (s[11]) begin
      n = {s[11:2], s[1] | s[0]};
      e = e + 9'd1;
    end else begin
      n = s[10:0] << sh;
      e = e - 9'(sh);
    end
    // Rounding carry ripples into the exponent field, covering subnormal->normal and ->inf.
    mag   = {(n[10] ? e[7:0] : 8'd0), n[9:3]} + 15'(n[2] & (n[1] | n[0] | n[3]));
    w_res = {lv[15], mag};
    if (e >= 9'd255) w_res = {lv[15], 8'hFF, 7'd0};
    if (s == 12'd0)  w_res = {lv[15] & sv[15], 15'd0};
    nan_a = (&inA[14:7]) && (|inA[6:0]);
    nan_b = (&inB[14:7]) && (|inB[6:0]);
    inf_a = (&inA[14:7]) && !(|inA[6:0]);
    inf_b = (&inB[14:7]) && !(|inB[6:0]);
    if (nan_a || nan_b || (inf_a && inf_b && (inA[15] != inB[15]))) w_res = 16'h7FC0;
    else if (inf_a) w_res = inA;
    else if (inf_b) w_res = inB;
  end

  if (LAT == 0) begin : g_comb
    assign out = w_res;
  end else begin : g_pipe
    logic [15:0] r_pipe [LAT];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_pipe <= '{default: '0};
      end else begin
        r_pipe[0] <= w_res;
        for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end
    assign out = r_pipe[LAT-1];
  end

endmodule

// File: rtl/bf16_max_select.sv
// Combinational BF16 max by ordering key; keeps operand a on a tie.
module bf16_max_select
  import softmax_max_sub_bf16_pkg::*;
(
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_max
);

  assign o_max = (bf16_key(i_b) > bf16_key(i_a)) ? i_b : i_a;

endmodule

// File: rtl/softmax_max_sub_bf16.sv
// Buffers one BF16 logit vector, tracks its max, then streams (x - max) to the exp unit.
module softmax_max_sub_bf16
  import softmax_max_sub_bf16_pkg::*;
#(
  parameter int unsigned VEC_LEN = 16,
  parameter int unsigned CNT_W   = $clog2(VEC_LEN),
  parameter int unsigned ADD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic [15:0] out_max
);

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(VEC_LEN - 1);
  localparam logic [1:0]       WAIT_INIT = (ADD_LAT > 0) ? 2'(ADD_LAT - 1) : 2'd0;

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_idx;
  logic [1:0]       r_wcnt;
  logic [15:0]      r_max, r_data;
  logic             r_last;
  logic [15:0]      r_buf [VEC_LEN];
  logic [15:0]      w_max_sel, w_add_a, w_add_b, w_add_out;
  logic             w_accept, w_idx_last, w_capture;

  assign in_ready   = (r_state == S_LOAD);
  assign out_valid  = (r_state == S_HOLD);
  assign out_data   = r_data;
  assign out_last   = r_last;
  assign out_max    = r_max;
  assign w_accept   = in_valid && in_ready;
  assign w_idx_last = (r_idx == LAST_IDX);
  assign w_add_a    = r_buf[r_idx];
  assign w_add_b    = r_max ^ BF16_SIGN;
  assign w_capture  = ((r_state == S_ISSUE) && (ADD_LAT == 0)) ||
                      ((r_state == S_WAIT) && (r_wcnt == 2'd0));

  bf16_max_select u_max_sel (
    .i_a   (r_max),
    .i_b   (in_data),
    .o_max (w_max_sel)
  );

  FP_ADD_BF16 #(
    .LAT (ADD_LAT)
  ) u_add (
    .clk (clk),
    .rst (rst),
    .inA (w_add_a),
    .inB (w_add_b),
    .out (w_add_out)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      S_LOAD:  if (w_accept && w_idx_last) w_state_d = S_ISSUE;
      S_ISSUE: w_state_d = (ADD_LAT == 0) ? S_HOLD : S_WAIT;
      S_WAIT:  if (r_wcnt == 2'd0) w_state_d = S_HOLD;
      S_HOLD:  if (out_ready) w_state_d = r_last ? S_LOAD : S_ISSUE;
      default: w_state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_idx   <= '0;
      r_wcnt  <= 2'd0;
      r_max   <= BF16_PZERO;
      r_data  <= BF16_PZERO;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_max <= (r_idx == '0) ? in_data : w_max_sel;
        r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
      end
      if (r_state == S_ISSUE) r_wcnt <= WAIT_INIT;
      else if (r_state == S_WAIT) r_wcnt <= r_wcnt - 2'd1;
      if (w_capture) begin
        r_data <= w_add_out;
        r_last <= w_idx_last;
      end
      if ((r_state == S_HOLD) && out_ready) r_idx <= r_last ? '0 : r_idx + 1'b1;
    end
  end

  // Vector storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_idx] <= in_data;
  end

endmodule

// File: tb/tb_softmax_max_sub_bf16.sv
// Self-checking bench: directed softmax vectors plus random vectors against a real-valued model.
module tb_softmax_max_sub_bf16;

  localparam int unsigned VecLen = 4;
  localparam int unsigned AddLat = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [15:0] in_data, out_data, out_max;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  softmax_max_sub_bf16 #(
    .VEC_LEN (VecLen),
    .ADD_LAT (AddLat)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_max   (out_max)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Exact value of a normal (or zero) BF16 number.
  function automatic real bf2r(input logic [15:0] b);
    real p;
    int  ex;
    ex = int'(b[14:7]);
    if (ex == 0) return 0.0;
    p = real'(128 + int'(b[6:0])) / 128.0;
    for (int i = 0; i < ex - 127; i++) p = p * 2.0;
    for (int i = 0; i < 127 - ex; i++) p = p / 2.0;
    return b[15] ? -p : p;
  endfunction

  // Round a real to BF16, nearest-even; exact zero maps to +0.
  function automatic logic [15:0] r2bf(input real v);
    real m, sc, fr;
    int  ex, ifl;
    logic sgn;
    if (v == 0.0) return 16'h0000;
    sgn = (v < 0.0);
    m   = sgn ? -v : v;
    ex  = 127;
    while (m >= 2.0) begin m = m / 2.0; ex++; end
    while (m < 1.0)  begin m = m * 2.0; ex--; end
    sc  = m * 128.0;
    ifl = int'($floor(sc));
    fr  = sc - $floor(sc);
    if (fr > 0.5 || (fr == 0.5 && (ifl % 2) == 1)) ifl++;
    if (ifl == 256) begin ifl = 128; ex++; end
    return {sgn, 8'(ex), ifl[6:0]};
  endfunction

  function automatic logic [15:0] model_max(input logic [15:0] v [VecLen]);
    logic [15:0] mx;
    mx = v[0];
    for (int i = 1; i < VecLen; i++) begin
      if (bf2r(v[i]) > bf2r(mx)) mx = v[i];
      else if (bf2r(v[i]) == 0.0 && bf2r(mx) == 0.0 && mx[15] && !v[i][15]) mx = v[i];
    end
    return mx;
  endfunction

  task automatic push(input logic [15:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("push_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [15:0] v [VecLen]);
    for (int i = 0; i < VecLen; i++) push(v[i]);
  endtask

  // Drains one vector with out_ready high while junk sits on the input port.
  task automatic drain(input string tag, input logic [15:0] emax, input logic [15:0] eout [VecLen]);
    int last_cyc = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h7F00;
    for (int k = 0; k < VecLen; k++) begin
      int n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      check({tag, ":valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, ":data"}, {16'd0, out_data}, {16'd0, eout[k]});
      check({tag, ":last"}, {31'd0, out_last}, {31'd0, k == VecLen - 1});
      check({tag, ":max"}, {16'd0, out_max}, {16'd0, emax});
      check({tag, ":in_ready"}, {31'd0, in_ready}, 32'd0);
      if (k > 0) check({tag, ":spacing"}, cyc - last_cyc, AddLat + 2);
      last_cyc = cyc;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [15:0] v [VecLen],
                          input logic [15:0] emax, input logic [15:0] eout [VecLen]);
    send_vec(v);
    drain(tag, emax, eout);
  endtask

  task automatic model_run(input string tag, input logic [15:0] v [VecLen]);
    logic [15:0] mx;
    logic [15:0] eo [VecLen];
    mx = model_max(v);
    for (int i = 0; i < VecLen; i++) eo[i] = r2bf(bf2r(v[i]) - bf2r(mx));
    send_vec(v);
    drain(tag, mx, eo);
  endtask

  function automatic logic [15:0] rnd_bf();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(123, 132)), 7'($urandom_range(0, 127))};
  endfunction

  initial begin
    logic [15:0] v [VecLen];
    logic [15:0] e [VecLen];
    logic [15:0] mx;
    int          n;
    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst:in_ready", {31'd0, in_ready}, 32'd1);
    check("rst:out_valid", {31'd0, out_valid}, 32'd0);
    check("rst:out_last", {31'd0, out_last}, 32'd0);
    check("rst:out_data", {16'd0, out_data}, 32'd0);
    check("rst:out_max", {16'd0, out_max}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    v = '{16'h3F80, 16'h4000, 16'hBF80, 16'h3F00};
    e = '{16'hBF80, 16'h0000, 16'hC040, 16'hBFC0};
    directed("basic", v, 16'h4000, e);

    v = '{16'h4120, 16'h4120, 16'h4120, 16'h4120};
    e = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    directed("ties", v, 16'h4120, e);

    v = '{16'h8000, 16'h0000, 16'hC000, 16'hBF80};
    e = '{16'h8000, 16'h0000, 16'hC000, 16'hBF80};
    directed("zeros", v, 16'h0000, e);

    // Back-pressure on the first output, then a second vector straight after.
    v = '{16'h3E00, 16'hC100, 16'h4080, 16'h3F80};
    mx = model_max(v);
    for (int i = 0; i < VecLen; i++) e[i] = r2bf(bf2r(v[i]) - bf2r(mx));
    send_vec(v);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    repeat (10) @(posedge clk);
    #1;
    check("bp:valid", {31'd0, out_valid}, 32'd1);
    check("bp:data", {16'd0, out_data}, {16'd0, e[0]});
    check("bp:last", {31'd0, out_last}, 32'd0);
    check("bp:in_ready", {31'd0, in_ready}, 32'd0);
    drain("bp", mx, e);
    v = '{16'hC0A0, 16'hC080, 16'hC100, 16'hC0A0};
    model_run("b2b", v);

    // Reset in the middle of loading.
    push(16'h4200);
    push(16'h4300);
    rst = 1'b1;
    #1;
    check("rst_load:in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_load:out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    v = '{16'h3F80, 16'h3F80, 16'h3F80, 16'h4040};
    e = '{16'hC000, 16'hC000, 16'hC000, 16'h0000};
    directed("after_rst", v, 16'h4040, e);

    // Reset while holding an output must drop out_valid without a clock edge.
    v = '{16'h4100, 16'h3F80, 16'h4000, 16'h3F00};
    send_vec(v);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("rst_hold:pre_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_hold:out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_hold:in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < VecLen; i++) begin
        v[i] = (i > 0 && $urandom_range(0, 3) == 0) ? v[i-1] : rnd_bf();
      end
      model_run("rand", v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
